// File: rtl/sram_1rwm_ctrl_pkg.sv
// rtl/sram_1rwm_ctrl_pkg.sv - shared types and parity helper for the masked-write SRAM controller
// SRAM_PARITY_EN selects one stored parity bit per lane.
package sram_1rwm_ctrl_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

`ifdef SRAM_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Callers zero-extend their lane into this width, so it bounds LANE_BITS.
  localparam int MAX_LANE_BITS = 64;

  function automatic logic lane_parity(input logic [MAX_LANE_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sram_1rwm_ctrl_if.sv
// rtl/sram_1rwm_ctrl_if.sv - request/response channels between a load-store unit and the SRAM controller
interface sram_1rwm_ctrl_if #(
  parameter int DEPTH     = 256,
  parameter int LANES     = 32,
  parameter int LANE_BITS = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = LANES * LANE_BITS;

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [W-1:0]     req_wdata;
  logic [LANES-1:0] req_wmask;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_rdata;
  logic [LANES-1:0] resp_perr;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_perr
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_perr
  );

endinterface

// File: rtl/sram_1rw_bank.sv
// rtl/sram_1rw_bank.sv - one lane bank: single-port array with registered read address
module sram_1rw_bank #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             volt_sel
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    raddr;
  logic             unused_volt_sel;

  // Voltage select belongs to the hard macro; the behavioural array has no use for it.
  assign unused_volt_sel = volt_sel;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    raddr     <= addr;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sram_1rwm_ctrl.sv
// rtl/sram_1rwm_ctrl.sv - masked-write SRAM controller: clear sweep, valid/ready handshake, response hold
// Optional per-lane parity when SRAM_PARITY_EN is defined.
module sram_1rwm_ctrl
  import sram_1rwm_ctrl_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int LANES     = 32,
  parameter int LANE_BITS = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            volt_sel,
  output logic            init_done,
  sram_1rwm_ctrl_if.slave bus
);
  localparam int AW              = $clog2(DEPTH);
  localparam int W               = LANES * LANE_BITS;
  localparam int LANE_STORE_BITS = LANE_BITS + PARITY_BITS;
  localparam logic [AW:0] LAST   = (AW+1)'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [AW:0]      cnt;
  logic             init_last, init_wr;
  logic             req_ready, req_fire, rd_acc;
  logic             resp_valid, fresh;
  logic [AW-1:0]    bank_addr;
  logic [W-1:0]     live_data, hold_data;
  logic [LANES-1:0] live_perr, hold_perr;

  assign init_last = (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_last) state_nxt = RUN;
  end

  always_comb begin
    init_wr   = 1'b0;
    req_ready = 1'b0;
    init_done = 1'b0;
    if (state == INIT) begin
      init_wr = 1'b1;
    end else begin
      req_ready = ~resp_valid | bus.resp_ready;
      init_done = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     cnt <= '0;
    else if (init_wr && !init_last) cnt <= cnt + 1'b1;
  end

  assign req_fire  = bus.req_valid & req_ready;
  assign rd_acc    = req_fire & ~bus.req_write;
  assign bank_addr = init_wr ? cnt[AW-1:0] : bus.req_addr;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_BITS-1:0]       wd;
    logic [LANE_STORE_BITS-1:0] st_wd, st_rd;
    logic                       en;

    assign wd = init_wr ? '0 : bus.req_wdata[i*LANE_BITS +: LANE_BITS];
    assign en = init_wr | (req_fire & (~bus.req_write | bus.req_wmask[i]));
`ifdef SRAM_PARITY_EN
    assign st_wd        = {lane_parity(MAX_LANE_BITS'(wd)), wd};
    assign live_perr[i] = lane_parity(MAX_LANE_BITS'(st_rd[LANE_BITS-1:0])) ^ st_rd[LANE_BITS];
`else
    assign st_wd        = wd;
    assign live_perr[i] = 1'b0;
`endif
    assign live_data[i*LANE_BITS +: LANE_BITS] = st_rd[LANE_BITS-1:0];

    sram_1rw_bank #(.DEPTH(DEPTH), .WIDTH(LANE_STORE_BITS)) u_bank (
      .clock    (clock),
      .en       (en),
      .we       (init_wr | bus.req_write),
      .addr     (bank_addr),
      .wdata    (st_wd),
      .rdata    (st_rd),
      .volt_sel (volt_sel)
    );
  end

  // The bank output is live only in the first response cycle; after that the
  // hold copy is shown so writes accepted on that edge cannot disturb it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      fresh      <= 1'b0;
      hold_data  <= '0;
      hold_perr  <= '0;
    end else begin
      fresh <= rd_acc;
      if (rd_acc)               resp_valid <= 1'b1;
      else if (bus.resp_ready)  resp_valid <= 1'b0;
      if (fresh) begin
        hold_data <= live_data;
        hold_perr <= live_perr;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = fresh ? live_data : hold_data;
  assign bus.resp_perr  = fresh ? live_perr : hold_perr;

endmodule

// File: tb/tb_sram_1rwm_ctrl.sv
// tb/tb_sram_1rwm_ctrl.sv - directed self-checking bench for sram_1rwm_ctrl (SRAM_PARITY_EN adds the parity case)
module tb_sram_1rwm_ctrl;
  localparam int DEPTH     = 256;
  localparam int LANES     = 32;
  localparam int LANE_BITS = 8;
  localparam int W         = LANES * LANE_BITS;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic volt_sel = 1'b0;
  logic init_done;
  int   n_pass   = 0;
  int   n_total  = 0;

  sram_1rwm_ctrl_if #(.DEPTH(DEPTH), .LANES(LANES), .LANE_BITS(LANE_BITS)) bus ();

  sram_1rwm_ctrl #(.DEPTH(DEPTH), .LANES(LANES), .LANE_BITS(LANE_BITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .volt_sel  (volt_sel),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chkp(input string tag, input logic [LANES-1:0] obs, input logic [LANES-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Counts cycles with init_done low, bounded so a stuck sweep cannot hang the run.
  task automatic count_init(output int n);
    logic leak;
    leak = 1'b0;
    n = 0;
    while (!init_done && n < 2000) begin
      if (bus.req_ready) leak = 1'b1;
      n++;
      step();
    end
    chk1("init_ready_low", leak, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [W-1:0] d, input logic [LANES-1:0] m);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    step();
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic do_read(input logic [7:0] a);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    step();
    bus.req_valid = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    logic [7:0]   b;
    logic [W-1:0] exp_w;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 8'd77;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b1;

    // Reset values
    repeat (3) step();
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chkw("rst_resp_rdata", bus.resp_rdata, '0);
    chkp("rst_resp_perr", bus.resp_perr, '0);
    chk1("rst_init_done", init_done, 1'b0);

    // Clear sweep lasts DEPTH cycles even with a request offered
    reset = 1'b0;
    bus.req_valid = 1'b1;
    count_init(n);
    chki("init_cycles", n, DEPTH);
    chk1("init_done_set", init_done, 1'b1);
    #1;
    chk1("run_ready", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk1("init_read_valid", bus.resp_valid, 1'b1);
    chkw("init_read_zero", bus.resp_rdata, '0);
    step();
    chk1("resp_retired", bus.resp_valid, 1'b0);

    // Masked write, then read-after-write on the next cycle
    do_write(8'd5, {32{8'hA5}}, 32'h0000_FFFF);
    do_read(8'd5);
    exp_w = {{16{8'h00}}, {16{8'hA5}}};
    chk1("mask_read_valid", bus.resp_valid, 1'b1);
    chkw("mask_read_data", bus.resp_rdata, exp_w);
    chkp("mask_read_perr", bus.resp_perr, '0);

    // wmask=0 consumes the request and leaves the word alone
    do_write(8'd5, {32{8'h11}}, 32'h0);
    do_read(8'd5);
    chkw("nomask_data", bus.resp_rdata, exp_w);

    // Top address, top lane only
    do_write(8'd255, {32{8'h3C}}, 32'h8000_0000);
    do_read(8'd255);
    chkw("top_addr_lane31", bus.resp_rdata, {8'h3C, {31{8'h00}}});

    // Backpressure: response held, write blocked until the handshake
    step();
    bus.resp_ready = 1'b0;
    do_read(8'd5);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'd5;
    bus.req_wdata = {32{8'hFF}};
    bus.req_wmask = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("bp_ready_low", bus.req_ready, 1'b0);
      chk1("bp_valid", bus.resp_valid, 1'b1);
      chkw("bp_hold_data", bus.resp_rdata, exp_w);
      step();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk1("bp_ready_release", bus.req_ready, 1'b1);
    chkw("bp_final_data", bus.resp_rdata, exp_w);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk1("bp_retired", bus.resp_valid, 1'b0);
    do_read(8'd5);
    chkw("bp_write_landed", bus.resp_rdata, {32{8'hFF}});

    // Back-to-back reads at full rate
    for (int k = 0; k < 16; k++) begin
      b = 8'(k * 11 + 5);
      do_write(8'(16 + k), {32{b}}, '1);
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.req_addr = 8'(16 + k);
      step();
      #1;
      b = 8'(k * 11 + 5);
      chk1("b2b_valid", bus.resp_valid, 1'b1);
      chk1("b2b_ready", bus.req_ready, 1'b1);
      chkw("b2b_data", bus.resp_rdata, {32{b}});
    end
    bus.req_valid = 1'b0;
    step();
    chk1("b2b_retired", bus.resp_valid, 1'b0);

`ifdef SRAM_PARITY_EN
    do_write(8'd9, {32{8'h12}}, '1);
    dut.g_lane[7].u_bank.mem[9][3] = ~dut.g_lane[7].u_bank.mem[9][3];
    do_read(8'd9);
    exp_w = {32{8'h12}};
    exp_w[59] = ~exp_w[59];
    chkp("parity_flip_perr", bus.resp_perr, 32'h0000_0080);
    chkw("parity_flip_data", bus.resp_rdata, exp_w);
    step();
`endif

    // Reset with a response pending, then reset in the middle of INIT
    bus.resp_ready = 1'b0;
    do_read(8'd5);
    chk1("pre_reset_valid", bus.resp_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk1("reset_drops_resp", bus.resp_valid, 1'b0);
    chk1("reset_init_done", init_done, 1'b0);
    chk1("reset_ready", bus.req_ready, 1'b0);
    bus.resp_ready = 1'b1;
    step();
    reset = 1'b0;
    repeat (100) step();
    chk1("mid_init_done_low", init_done, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_init(n);
    chki("reinit_cycles", n, DEPTH);
    do_read(8'd5);
    chkw("reinit_cleared", bus.resp_rdata, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
